sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one multi-cycle SRAM port between an instruction-fetch
// requester and a data (mem-stage) requester.
// Each access runs IDLE -> BUSY (ACCESS_LAT cycles) -> DONE (one-cycle ack).
// The ACCESS_LAT parameter is legal in the range 1..15.
// Optional feature macro: SRAM_ARB_RR_EN
//   undefined : fixed priority, the data port wins simultaneous requests
//   defined   : round-robin, the port not granted last wins simultaneous requests
module sram_arbiter #(
    parameter int ACCESS_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_ack_o,
    output logic        inst_stall_o,
    // data side
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ack_o,
    output logic        data_stall_o,
    // shared SRAM
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [3:0]  sram_sel_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} grant_t;

    // The counter is loaded so that it reaches zero in the last BUSY cycle.
    localparam logic [3:0] LAT_LOAD = 4'(ACCESS_LAT - 1);

    state_t     state;
    grant_t     grant;
    logic [3:0] cnt;
    grant_t     winner;

`ifdef SRAM_ARB_RR_EN
    grant_t last_grant;

    // Round-robin pick: on a tie the port that did not win last time is served.
    always_comb begin
        winner = GNT_INST;
        if (inst_req_i && data_req_i)
            winner = (last_grant == GNT_DATA) ? GNT_INST : GNT_DATA;
        else if (data_req_i)
            winner = GNT_DATA;
    end

    // Remember the most recent grant; reset to INST so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= GNT_INST;
        else if (state == IDLE && (inst_req_i || data_req_i))
            last_grant <= winner;
    end
`else
    // Fixed priority: a data request always beats a fetch request.
    always_comb begin
        winner = data_req_i ? GNT_DATA : GNT_INST;
    end
`endif

    // Stall while requesting and the access has not been acknowledged yet.
    assign inst_stall_o = inst_req_i & ~inst_ack_o;
    assign data_stall_o = data_req_i & ~data_ack_o;

    // Access sequencer: grant in IDLE, hold the SRAM bus in BUSY, ack in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= GNT_INST;
            cnt          <= 4'd0;
            inst_rdata_o <= 32'd0;
            data_rdata_o <= 32'd0;
            inst_ack_o   <= 1'b0;
            data_ack_o   <= 1'b0;
            sram_ce_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_sel_o   <= 4'd0;
            sram_addr_o  <= 32'd0;
            sram_wdata_o <= 32'd0;
        end else begin
            // acks are single-cycle pulses
            inst_ack_o <= 1'b0;
            data_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_req_i || data_req_i) begin
                        state     <= BUSY;
                        grant     <= winner;
                        cnt       <= LAT_LOAD;
                        sram_ce_o <= 1'b1;
                        if (winner == GNT_DATA) begin
                            sram_we_o    <= data_we_i;
                            sram_sel_o   <= data_sel_i;
                            sram_addr_o  <= data_addr_i;
                            sram_wdata_o <= data_wdata_i;
                        end else begin
                            // fetches are always full-word reads
                            sram_we_o    <= 1'b0;
                            sram_sel_o   <= 4'b1111;
                            sram_addr_o  <= inst_addr_i;
                            sram_wdata_o <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state        <= DONE;
                        sram_ce_o    <= 1'b0;
                        sram_we_o    <= 1'b0;
                        sram_sel_o   <= 4'd0;
                        sram_addr_o  <= 32'd0;
                        sram_wdata_o <= 32'd0;
                        if (grant == GNT_DATA) begin
                            data_ack_o <= 1'b1;
                            // writes leave the previously read word in place
                            if (!sram_we_o)
                                data_rdata_o <= sram_rdata_i;
                        end else begin
                            inst_ack_o   <= 1'b1;
                            inst_rdata_o <= sram_rdata_i;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a cycle-indexed transaction model of the arbiter.
// Honours SRAM_ARB_RR_EN for the expected arbitration order.
module tb_sram_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_we;
    logic [31:0] inst_addr, data_addr, data_wdata, sram_rdata;
    logic [3:0]  data_sel;
    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
    logic        inst_ack, inst_stall, data_ack, data_stall, sram_ce, sram_we;
    logic [3:0]  sram_sel;

    // second instance with single-cycle latency
    logic        l1_inst_req, l1_data_req, l1_data_we;
    logic [31:0] l1_inst_addr, l1_data_addr, l1_data_wdata, l1_sram_rdata;
    logic [3:0]  l1_data_sel;
    logic [31:0] l1_inst_rdata, l1_data_rdata, l1_sram_addr, l1_sram_wdata;
    logic        l1_inst_ack, l1_inst_stall, l1_data_ack, l1_data_stall, l1_sram_ce, l1_sram_we;
    logic [3:0]  l1_sram_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ACCESS_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata),
        .inst_ack_o(inst_ack), .inst_stall_o(inst_stall),
        .data_req_i(data_req), .data_we_i(data_we), .data_sel_i(data_sel),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
        .data_ack_o(data_ack), .data_stall_o(data_stall),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_sel_o(sram_sel),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    sram_arbiter #(.ACCESS_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .inst_req_i(l1_inst_req), .inst_addr_i(l1_inst_addr), .inst_rdata_o(l1_inst_rdata),
        .inst_ack_o(l1_inst_ack), .inst_stall_o(l1_inst_stall),
        .data_req_i(l1_data_req), .data_we_i(l1_data_we), .data_sel_i(l1_data_sel),
        .data_addr_i(l1_data_addr), .data_wdata_i(l1_data_wdata), .data_rdata_o(l1_data_rdata),
        .data_ack_o(l1_data_ack), .data_stall_o(l1_data_stall),
        .sram_ce_o(l1_sram_ce), .sram_we_o(l1_sram_we), .sram_sel_o(l1_sram_sel),
        .sram_addr_o(l1_sram_addr), .sram_wdata_o(l1_sram_wdata), .sram_rdata_i(l1_sram_rdata)
    );

    typedef struct {
        bit          is_data;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_irdata;
        logic [31:0] exp_drdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Arbitration rule from the requester's point of view (1 = data wins).
    function automatic bit pick_data(input bit ir, input bit dr, input bit last_data);
        if (ir && dr) begin
`ifdef SRAM_ARB_RR_EN
            return !last_data;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0; data_sel = 0;
        data_addr = 0; data_wdata = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1;
        idle_inputs();
        repeat (n) @(negedge clk);
        rst = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int ce_cnt;
        int ack_at;
        bit other_ack;
        @(negedge clk);
        inst_req   = !v.is_data;
        inst_addr  = v.is_data ? 32'h0 : v.addr;
        data_req   = v.is_data;
        data_we    = v.is_data ? v.we : 1'b1;
        data_sel   = v.is_data ? v.sel : 4'hF;
        data_addr  = v.is_data ? v.addr : 32'hFFFF_FFFC;
        data_wdata = v.is_data ? v.wdata : 32'h5A5A_5A5A;
        sram_rdata = v.rdata;
        ce_cnt = 0; ack_at = -1; other_ack = 0;
        for (int c = 0; c < 12 && ack_at < 0; c++) begin
            @(negedge clk);
            if (sram_ce) begin
                ce_cnt++;
                chk($sformatf("v%0d_addr", idx), sram_addr, v.addr);
                chk($sformatf("v%0d_we", idx), sram_we, v.exp_we);
                chk($sformatf("v%0d_sel", idx), sram_sel, v.exp_sel);
                if (v.is_data) chk($sformatf("v%0d_wdata", idx), sram_wdata, v.wdata);
            end
            if (v.is_data ? data_ack : inst_ack) ack_at = c;
            if (v.is_data ? inst_ack : data_ack) other_ack = 1;
            chk($sformatf("v%0d_stall", idx), v.is_data ? data_stall : inst_stall, ack_at < 0);
        end
        chk($sformatf("v%0d_ack_at", idx), ack_at, LAT);
        chk($sformatf("v%0d_ce_cycles", idx), ce_cnt, LAT);
        chk($sformatf("v%0d_other_ack", idx), other_ack, 0);
        chk($sformatf("v%0d_inst_rdata", idx), inst_rdata, v.exp_irdata);
        chk($sformatf("v%0d_data_rdata", idx), data_rdata, v.exp_drdata);
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", idx), {inst_ack, data_ack}, 0);
    endtask

    // model state for the randomized run
    int          e, g, d;
    bit          act, g_data, g_we, m_last_data, exp_busy, exp_ack;
    logic [3:0]  g_sel;
    logic [31:0] g_addr, g_wdata, m_ir, m_dr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // main stimulus
    initial begin
        int ce_cnt, ack_at, d_ack_at, i_ack_at, n;
        bit order[4];
        bit exp_order[4];

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h1C00_0000, 32'h0, 32'h0280_0C0C,
                    1'b0, 4'hF, 32'h0280_0C0C, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 4'b0010, 32'h0000_0100, 32'hAAAA_AAAA, 32'h1234_5678,
                    1'b1, 4'b0010, 32'h0280_0C0C, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF,
                    1'b0, 4'hF, 32'h0280_0C0C, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 4'b1000, 32'h0000_0204, 32'h0000_0055, 32'hFFFF_FFFF,
                    1'b1, 4'b1000, 32'h0280_0C0C, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h1C00_0004, 32'h0, 32'h0000_0013,
                    1'b0, 4'hF, 32'h0000_0013, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 4'b0001, 32'h0000_0208, 32'h0, 32'hCAFE_F00D,
                    1'b0, 4'b0001, 32'h0000_0013, 32'hCAFE_F00D};

        rst = 1;
        idle_inputs();
        sram_rdata = 32'h0;
        l1_inst_req = 0; l1_inst_addr = 0; l1_data_req = 0; l1_data_we = 0;
        l1_data_sel = 0; l1_data_addr = 0; l1_data_wdata = 0; l1_sram_rdata = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ce", sram_ce, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_sel", sram_sel, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_acks", {inst_ack, data_ack}, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_stalls", {inst_stall, data_stall}, 0);
        rst = 0;

        // directed vector table (data inputs carry noise with data_req=0 on fetches)
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // simultaneous requests right after reset: data first, fetch waits
        do_reset(2);
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C00_0010;
        data_req = 1; data_we = 0; data_sel = 4'hF; data_addr = 32'h0000_0300;
        sram_rdata = 32'h1111_2222;
        d_ack_at = -1; i_ack_at = -1;
        for (int c = 0; c < 20 && i_ack_at < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("both_first_addr", sram_addr, 32'h0000_0300);
            if (inst_ack) i_ack_at = c;
            chk("both_inst_stall", inst_stall, i_ack_at < 0);
            if (data_ack && d_ack_at < 0) begin
                d_ack_at = c;
                data_req = 0;
                sram_rdata = 32'h3333_4444;
            end
        end
        chk("both_data_ack_at", d_ack_at, LAT);
        chk("both_inst_ack_at", i_ack_at, 2 * (LAT + 2) - 2);
        chk("both_data_rdata", data_rdata, 32'h1111_2222);
        chk("both_inst_rdata", inst_rdata, 32'h3333_4444);
        idle_inputs();

        // both requesting continuously for four accesses
        do_reset(2);
`ifdef SRAM_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C00_0020;
        data_req = 1; data_we = 0; data_sel = 4'hF; data_addr = 32'h0000_0400;
        sram_rdata = 32'h7777_8888;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (inst_ack || data_ack) begin
                chk("cont_single_ack", inst_ack & data_ack, 0);
                order[n] = data_ack;
                n++;
            end
        end
        idle_inputs();
        chk("cont_count", n, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("cont_grant%0d", k), order[k], exp_order[k]);

        // reset in the second BUSY cycle aborts the access
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C00_0030; sram_rdata = 32'h9999_AAAA;
        @(negedge clk);
        chk("abort_busy1_ce", sram_ce, 1);
        @(negedge clk);
        chk("abort_busy2_ce", sram_ce, 1);
        rst = 1;
        @(negedge clk);
        chk("abort_ce", sram_ce, 0);
        chk("abort_acks", {inst_ack, data_ack}, 0);
        chk("abort_inst_rdata", inst_rdata, 0);
        chk("abort_data_rdata", data_rdata, 0);
        rst = 0;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", {inst_ack, data_ack, sram_ce}, 0);
        end

        // request dropped while BUSY: access still completes and acks
        @(negedge clk);
        data_req = 1; data_we = 0; data_sel = 4'hF; data_addr = 32'h0000_0500;
        sram_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        data_req = 0;
        chk("drop_ce0", sram_ce, 1);
        @(negedge clk);
        chk("drop_ce1", sram_ce, 1);
        @(negedge clk);
        chk("drop_ack", data_ack, 1);
        chk("drop_rdata", data_rdata, 32'h0BAD_F00D);
        chk("drop_stall", data_stall, 0);
        idle_inputs();

        // single-cycle latency instance: data read
        @(negedge clk);
        l1_data_req = 1; l1_data_we = 0; l1_data_sel = 4'hF; l1_data_addr = 32'h0000_0200;
        l1_sram_rdata = 32'h600D_CAFE;
        ce_cnt = 0; ack_at = -1;
        for (int c = 0; c < 8 && ack_at < 0; c++) begin
            @(negedge clk);
            if (l1_sram_ce) begin
                ce_cnt++;
                chk("l1_addr", l1_sram_addr, 32'h0000_0200);
                chk("l1_we_sel", {l1_sram_we, l1_sram_sel}, 5'b0_1111);
                chk("l1_wdata", l1_sram_wdata, 0);
            end
            if (l1_data_ack) ack_at = c;
            chk("l1_stall", l1_data_stall, ack_at < 0);
            chk("l1_inst_side", {l1_inst_ack, l1_inst_stall}, 0);
        end
        chk("l1_ce_cycles", ce_cnt, 1);
        chk("l1_ack_at", ack_at, 1);
        chk("l1_rdata", l1_data_rdata, 32'h600D_CAFE);
        chk("l1_inst_rdata", l1_inst_rdata, 0);
        l1_data_req = 0;
        @(negedge clk);
        chk("l1_ack_pulse", l1_data_ack, 0);

        // randomized run against the transaction model
        do_reset(2);
        act = 0; m_ir = 0; m_dr = 0; m_last_data = 0; e = 0; g = 0;
        g_data = 0; g_we = 0; g_sel = 0; g_addr = 0; g_wdata = 0;
        for (int i = 0; i < 400; i++) begin
            d = e - g;
            exp_busy = act && d >= 0 && d < LAT;
            exp_ack  = act && d == LAT;
            chk("rnd_ce", sram_ce, exp_busy);
            chk("rnd_we", sram_we, exp_busy && g_data && g_we);
            chk("rnd_inst_ack", inst_ack, exp_ack && !g_data);
            chk("rnd_data_ack", data_ack, exp_ack && g_data);
            chk("rnd_inst_rdata", inst_rdata, m_ir);
            chk("rnd_data_rdata", data_rdata, m_dr);
            chk("rnd_inst_stall", inst_stall, inst_req && !(exp_ack && !g_data));
            chk("rnd_data_stall", data_stall, data_req && !(exp_ack && g_data));
            if (exp_busy) begin
                chk("rnd_addr", sram_addr, g_addr);
                chk("rnd_sel", sram_sel, g_sel);
                if (g_data) chk("rnd_wdata", sram_wdata, g_wdata);
            end

            rst        = ($urandom_range(0, 59) == 0);
            inst_req   = $urandom_range(0, 1);
            inst_addr  = $urandom;
            data_req   = $urandom_range(0, 1);
            data_we    = $urandom_range(0, 1);
            data_sel   = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            sram_rdata = $urandom;

            // effect of the coming clock edge
            if (rst) begin
                act = 0; m_ir = 0; m_dr = 0; m_last_data = 0;
            end else begin
                if (act && (e + 1 - g) == LAT && !(g_data && g_we)) begin
                    if (g_data) m_dr = sram_rdata;
                    else        m_ir = sram_rdata;
                end
                if ((!act || (e + 1 - g) >= LAT + 2) && (inst_req || data_req)) begin
                    g_data      = pick_data(inst_req, data_req, m_last_data);
                    m_last_data = g_data;
                    act         = 1;
                    g           = e + 1;
                    g_we        = g_data ? data_we : 1'b0;
                    g_sel       = g_data ? data_sel : 4'hF;
                    g_addr      = g_data ? data_addr : inst_addr;
                    g_wdata     = data_wdata;
                end else if (act && (e + 1 - g) >= LAT + 2) begin
                    act = 0;
                end
            end
            e++;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
